uart_tx_arbiter: RTL and testbench

- Shares one `UART_sender` transmitter between two byte producers, e.g. the CPU peripheral-write path and a debug/result dumper.
- Each producer gets a small FIFO. A round-robin scheduler pops bytes and drives the sender's `tx_en`/`tx_data` handshake.
- Holds `tx_data` stable for the whole frame, because the sender samples it per bit.
- Enforces a guard interval after each frame. The sender drops `tx_status` back to 1 on the same edge it starts the stop bit, so without the guard the stop bit would last only about one cycle.
- Sits between the peripheral bus and `UART_sender`, in the same `quick_clk` domain.

---
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART_sender between two byte producers.
// Each producer has a small FIFO. The scheduler holds tx_data for the whole
// frame and inserts a guard interval after each frame, so the sender's stop
// bit keeps its full length.
module uart_tx_arbiter #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned GUARD       = 16,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic       quick_clk,
  input  logic       reset,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_en,
  input  logic       tx_status,
  output logic       busy,
  output logic       err_timeout,
  input  logic       err_clr
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned GuardW = $clog2(GUARD + 2);
  localparam int unsigned AckW   = $clog2(ACK_TIMEOUT + 2);

  localparam logic [CntW-1:0]   DepthC = CntW'(DEPTH);
  localparam logic [GuardW-1:0] GuardC = GuardW'(GUARD);
  localparam logic [AckW-1:0]   AckMax = AckW'(ACK_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StWaitAck, StWaitDone, StGuard} state_e;

  state_e            state_q;
  logic              last_grant_q;
  logic [AckW-1:0]   ack_cnt_q;
  logic [GuardW-1:0] guard_cnt_q;

  // Per-requester FIFO storage, index 0 = req0, index 1 = req1
  logic [7:0]           mem_q [2][DEPTH];
  logic [1:0][PtrW-1:0] wr_q;
  logic [1:0][PtrW-1:0] rd_q;
  logic [1:0][CntW-1:0] cnt_q;

  logic [1:0][7:0] in_data;
  logic [1:0]      in_valid;
  logic [1:0]      push;
  logic [1:0]      pop;
  logic [1:0]      nonempty;
  logic            grant;
  logic            win;
  logic [7:0]      head_data;

  assign in_data  = {req1_data, req0_data};
  assign in_valid = {req1_valid, req0_valid};

  assign req0_ready = (cnt_q[0] != DepthC);
  assign req1_ready = (cnt_q[1] != DepthC);
  assign busy       = (state_q != StIdle);

  // Grant decision: a lone non-empty FIFO wins, a tie goes to the one not served last
  always_comb begin
    push      = 2'b00;
    pop       = 2'b00;
    nonempty  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      nonempty[i] = (cnt_q[i] != '0);
      push[i]     = in_valid[i] & (cnt_q[i] != DepthC);
    end
    win       = (nonempty == 2'b11) ? ~last_grant_q : nonempty[1];
    grant     = (state_q == StIdle) & (|nonempty) & tx_status;
    pop[0]    = grant & ~win;
    pop[1]    = grant & win;
    head_data = mem_q[win][rd_q[win]];
  end

  // FIFO payload storage; contents need no reset because pointers gate reads
  always_ff @(posedge quick_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wr_q[i]] <= in_data[i];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge quick_clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_q[i] <= wr_q[i] + PtrW'(1);
        if (pop[i])  rd_q[i] <= rd_q[i] + PtrW'(1);
        if (push[i] && !pop[i]) begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end else if (!push[i] && pop[i]) begin
          cnt_q[i] <= cnt_q[i] - CntW'(1);
        end
      end
    end
  end

  // Scheduler FSM with registered sender handshake and sticky timeout flag
  always_ff @(posedge quick_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      ack_cnt_q    <= '0;
      guard_cnt_q  <= '0;
      tx_en        <= 1'b0;
      tx_data      <= 8'h00;
      err_timeout  <= 1'b0;
    end else begin
      tx_en <= 1'b0;
      // Clear first so a timeout set later in this block takes priority
      if (err_clr) err_timeout <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            tx_data      <= head_data;
            tx_en        <= 1'b1;
            last_grant_q <= win;
            ack_cnt_q    <= '0;
            state_q      <= StWaitAck;
          end
        end
        StWaitAck: begin
          if (!tx_status) begin
            state_q <= StWaitDone;
          end else if (ack_cnt_q + AckW'(1) == AckMax) begin
            // Sender never started: flag it and retry with the same byte
            err_timeout <= 1'b1;
            tx_en       <= 1'b1;
            ack_cnt_q   <= '0;
          end else begin
            ack_cnt_q <= ack_cnt_q + AckW'(1);
          end
        end
        StWaitDone: begin
          if (tx_status) begin
            guard_cnt_q <= GuardC;
            state_q     <= StGuard;
          end
        end
        StGuard: begin
          if (guard_cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            guard_cnt_q <= guard_cnt_q - GuardW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple behavioural sender model.
module tb_uart_tx_arbiter;

  localparam int unsigned Guard    = 16;
  localparam int          FrameLen = 20;
  localparam int          Limit    = 3000;

  logic       quick_clk = 1'b0;
  logic       reset     = 1'b1;
  logic [7:0] req0_data, req1_data;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_status = 1'b1;
  logic       busy;
  logic       err_timeout;
  logic       err_clr;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(
    .DEPTH      (4),
    .GUARD      (Guard),
    .ACK_TIMEOUT(4)
  ) dut (
    .quick_clk  (quick_clk),
    .reset      (reset),
    .req0_data  (req0_data),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req1_data  (req1_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .tx_status  (tx_status),
    .busy       (busy),
    .err_timeout(err_timeout),
    .err_clr    (err_clr)
  );

  always #5 quick_clk = ~quick_clk;

  // Sender model: accepts tx_en when idle, stays busy FrameLen cycles
  logic       model_en;
  logic [7:0] frame_data;
  logic [7:0] sent_q [$];
  int         frame_cnt;
  int         cyc       = 0;
  int         rise_cyc  = 0;
  bit         have_rise = 1'b0;
  int         min_gap   = 1000;
  int         hold_err  = 0;
  int         txen_cnt  = 0;

  always @(posedge quick_clk) cyc <= cyc + 1;

  always @(posedge quick_clk or negedge reset) begin
    if (!reset) begin
      tx_status <= 1'b1;
      frame_cnt <= 0;
      have_rise <= 1'b0;
    end else begin
      if (tx_en) txen_cnt <= txen_cnt + 1;
      if (tx_status) begin
        if (model_en && tx_en) begin
          tx_status  <= 1'b0;
          frame_cnt  <= FrameLen - 1;
          frame_data <= tx_data;
          sent_q.push_back(tx_data);
          if (have_rise && (cyc - rise_cyc) < min_gap) min_gap <= cyc - rise_cyc;
        end
      end else begin
        if (tx_data != frame_data) hold_err <= hold_err + 1;
        if (frame_cnt == 0) begin
          tx_status <= 1'b1;
          rise_cyc  <= cyc;
          have_rise <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge quick_clk);
    reset      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    err_clr    = 1'b0;
    model_en   = 1'b1;
    repeat (2) @(negedge quick_clk);
    reset = 1'b1;
    @(negedge quick_clk);
  endtask

  task automatic wait_sent(input int n, input string tag);
    int k = 0;
    while (!(sent_q.size() >= n && !busy && tx_status) && k < Limit) begin
      @(negedge quick_clk);
      k++;
    end
    check({tag, "_done"}, 32'(k < Limit), 1);
  endtask

  task automatic wait_frame_start(input string tag);
    int k = 0;
    while (tx_status && k < Limit) begin
      @(negedge quick_clk);
      k++;
    end
    check({tag, "_start"}, 32'(k < Limit), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int en_base;
    int k;
    logic [7:0] exp_c [4];
    req0_data  = 8'h00;
    req1_data  = 8'h00;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    err_clr    = 1'b0;
    model_en   = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge quick_clk);
    reset = 1'b1;
    @(negedge quick_clk);

    // Reset state
    check("rst_ready0", 32'(req0_ready), 1);
    check("rst_ready1", 32'(req1_ready), 1);
    check("rst_txen", 32'(tx_en), 0);
    check("rst_txdata", 32'(tx_data), 32'h00);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err_timeout), 0);

    // Single byte: push at edge E, tx_en high E+1..E+2
    base       = sent_q.size();
    req0_data  = 8'hA5;
    req0_valid = 1'b1;
    @(negedge quick_clk);
    req0_valid = 1'b0;
    check("t1_txen_e", 32'(tx_en), 0);
    @(negedge quick_clk);
    check("t1_txen_e1", 32'(tx_en), 1);
    check("t1_data_e1", 32'(tx_data), 32'hA5);
    check("t1_busy", 32'(busy), 1);
    @(negedge quick_clk);
    check("t1_txen_e2", 32'(tx_en), 0);
    wait_sent(base + 1, "t1");
    check("t1_byte", 32'(sent_q[base]), 32'hA5);
    check("t1_hold", 32'(tx_data), 32'hA5);

    // Contention: strict alternation starting with req0
    do_reset();
    base       = sent_q.size();
    req0_data  = 8'h11;
    req1_data  = 8'h33;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge quick_clk);
    req0_data = 8'h22;
    req1_data = 8'h44;
    @(negedge quick_clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_sent(base + 4, "t2");
    exp_c[0] = 8'h11;
    exp_c[1] = 8'h33;
    exp_c[2] = 8'h22;
    exp_c[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_order%0d", i), 32'(sent_q[base + i]), 32'(exp_c[i]));
    end
    check("t2_guard_gap", 32'(min_gap >= int'(Guard)), 1);

    // FIFO full on req1 while sender is busy
    do_reset();
    base       = sent_q.size();
    req0_data  = 8'h77;
    req0_valid = 1'b1;
    @(negedge quick_clk);
    req0_valid = 1'b0;
    wait_frame_start("t3");
    for (int i = 0; i < 5; i++) begin
      req1_data  = 8'h51 + 8'(i);
      req1_valid = 1'b1;
      check($sformatf("t3_ready%0d", i), 32'(req1_ready), 32'(i < 4));
      @(negedge quick_clk);
    end
    req1_valid = 1'b0;
    check("t3_ready_full", 32'(req1_ready), 0);
    k = 0;
    while (!req1_ready && k < Limit) begin
      @(negedge quick_clk);
      k++;
    end
    check("t3_ready_ret", 32'(k < Limit), 1);
    check("t3_pop_txen", 32'(tx_en), 1);
    check("t3_pop_data", 32'(tx_data), 32'h51);
    wait_sent(base + 5, "t3");
    check("t3_order0", 32'(sent_q[base]), 32'h77);
    for (int i = 1; i < 5; i++) begin
      check($sformatf("t3_order%0d", i), 32'(sent_q[base + i]), 32'h50 + 32'(i));
    end
    check("t3_count", 32'(sent_q.size() - base), 5);

    // Ack timeout: model ignores tx_en
    do_reset();
    base       = sent_q.size();
    model_en   = 1'b0;
    req0_data  = 8'hC3;
    req0_valid = 1'b1;
    @(negedge quick_clk);
    req0_valid = 1'b0;
    @(negedge quick_clk);
    check("t4_txen", 32'(tx_en), 1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge quick_clk);
      check($sformatf("t4_quiet_en%0d", i), 32'(tx_en), 0);
      check($sformatf("t4_quiet_err%0d", i), 32'(err_timeout), 0);
    end
    @(negedge quick_clk);
    check("t4_err_set", 32'(err_timeout), 1);
    check("t4_retry_en", 32'(tx_en), 1);
    check("t4_retry_data", 32'(tx_data), 32'hC3);
    model_en = 1'b1;
    wait_sent(base + 1, "t4");
    check("t4_byte", 32'(sent_q[base]), 32'hC3);
    check("t4_err_sticky", 32'(err_timeout), 1);
    err_clr = 1'b1;
    @(negedge quick_clk);
    err_clr = 1'b0;
    check("t4_err_clr", 32'(err_timeout), 0);

    // Reset mid-frame with bytes queued
    do_reset();
    req0_data  = 8'hAA;
    req0_valid = 1'b1;
    @(negedge quick_clk);
    req0_valid = 1'b0;
    wait_frame_start("t5");
    @(negedge quick_clk);
    req0_data  = 8'h01;
    req1_data  = 8'h02;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge quick_clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("t5_busy_pre", 32'(busy), 1);
    reset = 1'b0;
    #1;
    check("t5_txen", 32'(tx_en), 0);
    check("t5_txdata", 32'(tx_data), 32'h00);
    check("t5_busy", 32'(busy), 0);
    check("t5_ready0", 32'(req0_ready), 1);
    check("t5_ready1", 32'(req1_ready), 1);
    @(negedge quick_clk);
    reset   = 1'b1;
    en_base = txen_cnt;
    repeat (100) @(negedge quick_clk);
    check("t5_no_txen", 32'(txen_cnt - en_base), 0);
    check("t5_idle", 32'(busy), 0);

    // Pointer wrap: ten bytes through req0
    do_reset();
    base = sent_q.size();
    for (int i = 0; i < 10; i++) begin
      req0_data  = 8'(i);
      req0_valid = 1'b1;
      k = 0;
      while (!req0_ready && k < Limit) begin
        @(negedge quick_clk);
        k++;
      end
      check($sformatf("t6_push%0d", i), 32'(k < Limit), 1);
      @(negedge quick_clk);
    end
    req0_valid = 1'b0;
    wait_sent(base + 10, "t6");
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t6_order%0d", i), 32'(sent_q[base + i]), 32'(i));
    end
    check("t6_empty", 32'(req0_ready), 1);
    check("t6_hold", 32'(hold_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
